// File: rtl/issue_register_read_if.sv
// Shared types and the RS -> register-read -> FU bundle; the slave modport is the register-read stage.
package issue_register_read_pkg;
   localparam int PHY_REGS   = 64;
   localparam int PHY_W      = $clog2(PHY_REGS);
   localparam int ROB_WIDTH  = 4;
   localparam int DATA_WIDTH = 32;

   typedef struct packed {
      logic [31:0]           addr;
      logic [ROB_WIDTH-1:0]  rob_id;
      logic [6:0]            funct7;
      logic [2:0]            funct3;
      logic [PHY_W-1:0]      rs1_phy;
      logic [PHY_W-1:0]      rs2_phy;
      logic [PHY_W-1:0]      rd_phy;
      logic [31:0]           immediate;
      logic [6:0]            opcode;
      logic                  predict_taken;
      logic [31:0]           predict_target;
      logic [ROB_WIDTH-1:0]  age;
      logic                  valid;
   } RS_ENTRY_t;
endpackage

interface issue_register_read_if;
   localparam int PHY_W      = issue_register_read_pkg::PHY_W;
   localparam int ROB_WIDTH  = issue_register_read_pkg::ROB_WIDTH;
   localparam int DATA_WIDTH = issue_register_read_pkg::DATA_WIDTH;

   logic                                flush;
   issue_register_read_pkg::RS_ENTRY_t  issue_instruction;
   logic                                issue_valid;
   logic                                busy;
   logic [PHY_W-1:0]                    prf_raddr1;
   logic [PHY_W-1:0]                    prf_raddr2;
   logic [DATA_WIDTH-1:0]               prf_rdata1;
   logic [DATA_WIDTH-1:0]               prf_rdata2;
   logic                                wb_valid;
   logic [PHY_W-1:0]                    wb_rd_phy;
   logic [DATA_WIDTH-1:0]               wb_data;
   logic                                ex_valid;
   logic                                ex_ready;
   logic [ROB_WIDTH-1:0]                ex_rob_id;
   logic [PHY_W-1:0]                    ex_rd_phy;
   logic [6:0]                          ex_opcode;
   logic [2:0]                          ex_funct3;
   logic [6:0]                          ex_funct7;
   logic [31:0]                         ex_addr;
   logic [31:0]                         ex_imm;
   logic [DATA_WIDTH-1:0]               ex_op1;
   logic [DATA_WIDTH-1:0]               ex_op2;
   logic                                ex_predict_taken;
   logic [31:0]                         ex_predict_target;

   modport master (
      output flush, issue_instruction, issue_valid, prf_rdata1, prf_rdata2,
             wb_valid, wb_rd_phy, wb_data, ex_ready,
      input  busy, prf_raddr1, prf_raddr2, ex_valid, ex_rob_id, ex_rd_phy,
             ex_opcode, ex_funct3, ex_funct7, ex_addr, ex_imm, ex_op1, ex_op2,
             ex_predict_taken, ex_predict_target
   );

   modport slave (
      input  flush, issue_instruction, issue_valid, prf_rdata1, prf_rdata2,
             wb_valid, wb_rd_phy, wb_data, ex_ready,
      output busy, prf_raddr1, prf_raddr2, ex_valid, ex_rob_id, ex_rd_phy,
             ex_opcode, ex_funct3, ex_funct7, ex_addr, ex_imm, ex_op1, ex_op2,
             ex_predict_taken, ex_predict_target
   );
endinterface

// File: rtl/issue_register_read.sv
// Register-read stage: S1 reads the PRF (with writeback bypass), S2 latches the FU packet; 2-cycle latency.
// Valid/ready towards the FU; busy stalls the RS while a held S2 blocks S1.
module issue_register_read #(
   parameter int PHY_REGS   = issue_register_read_pkg::PHY_REGS,
   parameter int ROB_WIDTH  = issue_register_read_pkg::ROB_WIDTH,
   parameter int DATA_WIDTH = issue_register_read_pkg::DATA_WIDTH
) (
   input logic                     clk,
   input logic                     rst,
   issue_register_read_if.slave    bus
);
   localparam int PHY_W = $clog2(PHY_REGS);

   issue_register_read_pkg::RS_ENTRY_t s1_ent;
   logic                  s1_valid;
   logic                  flag1, flag2;
   logic [DATA_WIDTH-1:0] byp1, byp2;

   logic                  s2_valid;
   logic [ROB_WIDTH-1:0]  s2_rob_id;
   logic [PHY_W-1:0]      s2_rd_phy;
   logic [6:0]            s2_opcode;
   logic [2:0]            s2_funct3;
   logic [6:0]            s2_funct7;
   logic [31:0]           s2_addr;
   logic [31:0]           s2_imm;
   logic [DATA_WIDTH-1:0] s2_op1, s2_op2;
   logic                  s2_predict_taken;
   logic [31:0]           s2_predict_target;

   logic                  s2_free, s1_adv, accept;
   logic [PHY_W-1:0]      raddr1, raddr2;
   logic                  hit1, hit2;
   logic [DATA_WIDTH-1:0] op1_res, op2_res;
   logic                  unused_fields;

   assign s2_free  = !s2_valid || bus.ex_ready;
   assign s1_adv   = s1_valid && s2_free;
   assign bus.busy = s1_valid && !s2_free && !bus.flush;
   assign accept   = bus.issue_valid && !bus.busy && !bus.flush;

   // A stalled S1 keeps re-reading its own sources so late writebacks are caught.
   assign raddr1 = (s1_valid && !s1_adv) ? s1_ent.rs1_phy : bus.issue_instruction.rs1_phy;
   assign raddr2 = (s1_valid && !s1_adv) ? s1_ent.rs2_phy : bus.issue_instruction.rs2_phy;
   assign bus.prf_raddr1 = raddr1;
   assign bus.prf_raddr2 = raddr2;

   assign hit1 = bus.wb_valid && (bus.wb_rd_phy == raddr1) && (raddr1 != '0);
   assign hit2 = bus.wb_valid && (bus.wb_rd_phy == raddr2) && (raddr2 != '0);

   assign op1_res = (s1_ent.rs1_phy == '0) ? '0 : (flag1 ? byp1 : bus.prf_rdata1);
   assign op2_res = (s1_ent.rs2_phy == '0) ? '0 : (flag2 ? byp2 : bus.prf_rdata2);

   assign unused_fields = ^{s1_ent.age, s1_ent.valid};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid <= 1'b0;
         s1_ent   <= '0;
         flag1    <= 1'b0;
         flag2    <= 1'b0;
         byp1     <= '0;
         byp2     <= '0;
      end else begin
         flag1 <= hit1;
         flag2 <= hit2;
         if (hit1) byp1 <= bus.wb_data;
         if (hit2) byp2 <= bus.wb_data;
         if (bus.flush) begin
            s1_valid <= 1'b0;
         end else if (accept) begin
            s1_valid <= 1'b1;
            s1_ent   <= bus.issue_instruction;
         end else if (s1_adv) begin
            s1_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s2_valid          <= 1'b0;
         s2_rob_id         <= '0;
         s2_rd_phy         <= '0;
         s2_opcode         <= '0;
         s2_funct3         <= '0;
         s2_funct7         <= '0;
         s2_addr           <= '0;
         s2_imm            <= '0;
         s2_op1            <= '0;
         s2_op2            <= '0;
         s2_predict_taken  <= 1'b0;
         s2_predict_target <= '0;
      end else if (bus.flush) begin
         s2_valid <= 1'b0;
      end else if (s1_adv) begin
         s2_valid          <= 1'b1;
         s2_rob_id         <= s1_ent.rob_id;
         s2_rd_phy         <= s1_ent.rd_phy;
         s2_opcode         <= s1_ent.opcode;
         s2_funct3         <= s1_ent.funct3;
         s2_funct7         <= s1_ent.funct7;
         s2_addr           <= s1_ent.addr;
         s2_imm            <= s1_ent.immediate;
         s2_op1            <= op1_res;
         s2_op2            <= op2_res;
         s2_predict_taken  <= s1_ent.predict_taken;
         s2_predict_target <= s1_ent.predict_target;
      end else if (bus.ex_ready) begin
         s2_valid <= 1'b0;
      end
   end

   assign bus.ex_valid          = s2_valid;
   assign bus.ex_rob_id         = s2_rob_id;
   assign bus.ex_rd_phy         = s2_rd_phy;
   assign bus.ex_opcode         = s2_opcode;
   assign bus.ex_funct3         = s2_funct3;
   assign bus.ex_funct7         = s2_funct7;
   assign bus.ex_addr           = s2_addr;
   assign bus.ex_imm            = s2_imm;
   assign bus.ex_op1            = s2_op1;
   assign bus.ex_op2            = s2_op2;
   assign bus.ex_predict_taken  = s2_predict_taken;
   assign bus.ex_predict_target = s2_predict_target;
endmodule

// File: tb/tb_issue_register_read.sv
// Directed bench with a read-before-write PRF model and an in-order packet scoreboard.
module tb_issue_register_read;
   import issue_register_read_pkg::*;

   typedef struct {
      logic [3:0]   rob;
      logic [31:0]  op1;
      logic [31:0]  op2;
      logic [127:0] misc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   failures = 0;
   exp_t exp_q[$];
   exp_t mon_e;
   logic [31:0] prf [0:63] = '{default: '0};

   issue_register_read_if bus();

   issue_register_read dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      bus.prf_rdata1 <= prf[bus.prf_raddr1];
      bus.prf_rdata2 <= prf[bus.prf_raddr2];
      if (bus.wb_valid) prf[bus.wb_rd_phy] <= bus.wb_data;
   end

   task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic RS_ENTRY_t mk(int rob, int rs1, int rs2);
      RS_ENTRY_t e;
      e                = '0;
      e.addr           = 32'(32'h1000 + rob * 4);
      e.rob_id         = rob[3:0];
      e.funct7         = 7'(rob * 3 + 1);
      e.funct3         = rob[2:0];
      e.rs1_phy        = rs1[5:0];
      e.rs2_phy        = rs2[5:0];
      e.rd_phy         = 6'(rob + 32);
      e.immediate      = 32'(32'hABC0_0000 + rob);
      e.opcode         = 7'h33;
      e.predict_taken  = rob[0];
      e.predict_target = 32'(32'h2000 + rob * 8);
      e.age            = rob[3:0];
      e.valid          = 1'b1;
      return e;
   endfunction

   function automatic logic [127:0] misc_of(RS_ENTRY_t e);
      return {8'h0, e.rd_phy, e.opcode, e.funct3, e.funct7, e.addr, e.immediate,
              e.predict_taken, e.predict_target};
   endfunction

   task automatic issue(RS_ENTRY_t e, logic [31:0] o1, logic [31:0] o2);
      exp_t x;
      bus.issue_instruction = e;
      bus.issue_valid       = 1'b1;
      x.rob  = e.rob_id;
      x.op1  = o1;
      x.op2  = o2;
      x.misc = misc_of(e);
      exp_q.push_back(x);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Every FU handshake must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst && bus.ex_valid && bus.ex_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL unexpected_packet observed rob=%0h expected none", bus.ex_rob_id);
         end else begin
            mon_e = exp_q.pop_front();
            chk("pkt_rob_id", 128'(bus.ex_rob_id), 128'(mon_e.rob));
            chk("pkt_op1", 128'(bus.ex_op1), 128'(mon_e.op1));
            chk("pkt_op2", 128'(bus.ex_op2), 128'(mon_e.op2));
            chk("pkt_fields", {8'h0, bus.ex_rd_phy, bus.ex_opcode, bus.ex_funct3, bus.ex_funct7,
                               bus.ex_addr, bus.ex_imm, bus.ex_predict_taken,
                               bus.ex_predict_target}, mon_e.misc);
         end
      end
   end

   initial begin
      bus.flush             = 1'b0;
      bus.issue_instruction = '0;
      bus.issue_valid       = 1'b0;
      bus.wb_valid          = 1'b0;
      bus.wb_rd_phy         = '0;
      bus.wb_data           = '0;
      bus.ex_ready          = 1'b0;

      tick();
      chk("reset_ex_valid", 128'(bus.ex_valid), 128'(0));
      chk("reset_busy", 128'(bus.busy), 128'(0));
      chk("reset_ex_op1", 128'(bus.ex_op1), 128'(0));
      rst = 1'b1;

      // Preload PRF through the writeback port.
      bus.wb_valid = 1'b1; bus.wb_rd_phy = 6'd5; bus.wb_data = 32'h11;
      tick();
      bus.wb_rd_phy = 6'd6; bus.wb_data = 32'h22;
      tick();
      bus.wb_valid = 1'b0;

      // Basic latency.
      bus.ex_ready = 1'b1;
      issue(mk(3, 5, 6), 32'h11, 32'h22);
      tick();
      bus.issue_valid = 1'b0;
      chk("lat_cycle1_ex_valid", 128'(bus.ex_valid), 128'(0));
      tick();
      chk("lat_cycle2_ex_valid", 128'(bus.ex_valid), 128'(1));
      tick();
      chk("lat_drained", 128'(bus.ex_valid), 128'(0));

      // Back-to-back issues: no bubbles.
      for (int i = 0; i < 6; i++) begin
         issue(mk(4 + i, 5, 6), 32'h11, 32'h22);
         tick();
         if (i >= 1) chk("b2b_ex_valid", 128'(bus.ex_valid), 128'(1));
      end
      bus.issue_valid = 1'b0;
      tick();
      chk("b2b_tail_valid", 128'(bus.ex_valid), 128'(1));
      tick();
      chk("b2b_empty", 128'(bus.ex_valid), 128'(0));

      // Same-cycle writeback bypass, then the zero register.
      bus.wb_valid = 1'b1; bus.wb_rd_phy = 6'd7; bus.wb_data = 32'h99;
      issue(mk(10, 7, 6), 32'h99, 32'h22);
      tick();
      bus.wb_valid = 1'b0; bus.issue_valid = 1'b0;
      tick(); tick();
      bus.wb_valid = 1'b1; bus.wb_rd_phy = 6'd0; bus.wb_data = 32'h55;
      issue(mk(11, 0, 5), 32'h0, 32'h11);
      tick();
      bus.wb_valid = 1'b0; bus.issue_valid = 1'b0;
      tick(); tick();

      // Stall: S1 held, re-reads its own sources, picks up a writeback.
      bus.ex_ready = 1'b0;
      issue(mk(1, 5, 6), 32'h11, 32'h22);
      tick();
      issue(mk(2, 6, 9), 32'h22, 32'hABCD);
      tick();
      bus.issue_valid       = 1'b0;
      bus.issue_instruction = mk(12, 12, 13);
      #1;
      chk("stall_busy", 128'(bus.busy), 128'(1));
      chk("stall_ex_valid", 128'(bus.ex_valid), 128'(1));
      chk("stall_raddr1", 128'(bus.prf_raddr1), 128'(6));
      chk("stall_raddr2", 128'(bus.prf_raddr2), 128'(9));
      bus.wb_valid = 1'b1; bus.wb_rd_phy = 6'd9; bus.wb_data = 32'hABCD;
      tick();
      bus.wb_valid = 1'b0;
      chk("stall_busy_hold", 128'(bus.busy), 128'(1));
      chk("stall_s2_stable", 128'(bus.ex_rob_id), 128'(1));
      bus.ex_ready = 1'b1;
      #1;
      chk("release_busy", 128'(bus.busy), 128'(0));
      tick();
      chk("release_second", 128'(bus.ex_rob_id), 128'(2));
      tick();
      chk("release_empty", 128'(bus.ex_valid), 128'(0));

      // Flush with a full pipeline and a concurrent issue.
      bus.ex_ready = 1'b0;
      issue(mk(13, 5, 6), 32'h11, 32'h22);
      tick();
      issue(mk(14, 6, 5), 32'h22, 32'h11);
      tick();
      chk("full_busy", 128'(bus.busy), 128'(1));
      bus.issue_instruction = mk(15, 5, 5);
      bus.issue_valid = 1'b1;
      bus.flush       = 1'b1;
      #1;
      chk("flush_busy", 128'(bus.busy), 128'(0));
      tick();
      bus.flush = 1'b0; bus.issue_valid = 1'b0;
      chk("flush_ex_valid", 128'(bus.ex_valid), 128'(0));
      chk("flush_busy_after", 128'(bus.busy), 128'(0));
      exp_q.delete();
      bus.ex_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("flush_no_output", 128'(bus.ex_valid), 128'(0));
      end

      // Asynchronous reset in the middle of a stall.
      bus.ex_ready = 1'b0;
      issue(mk(6, 5, 6), 32'h11, 32'h22);
      tick();
      issue(mk(7, 6, 5), 32'h22, 32'h11);
      tick();
      bus.issue_valid = 1'b0;
      chk("prereset_busy", 128'(bus.busy), 128'(1));
      #2;
      rst = 1'b0;
      #1;
      chk("arst_ex_valid", 128'(bus.ex_valid), 128'(0));
      chk("arst_busy", 128'(bus.busy), 128'(0));
      chk("arst_ex_op1", 128'(bus.ex_op1), 128'(0));
      chk("arst_ex_rob_id", 128'(bus.ex_rob_id), 128'(0));
      chk("arst_ex_addr", 128'(bus.ex_addr), 128'(0));
      exp_q.delete();
      @(negedge clk);
      rst = 1'b1;
      tick();
      bus.ex_ready = 1'b1;
      issue(mk(8, 5, 6), 32'h11, 32'h22);
      tick();
      bus.issue_valid = 1'b0;
      chk("post_rst_lat1", 128'(bus.ex_valid), 128'(0));
      tick();
      chk("post_rst_lat2", 128'(bus.ex_valid), 128'(1));
      tick(); tick(); tick();
      chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/issue_register_read.md
Name: issue_register_read

Overview:
Downstream neighbour of the reservation station. It accepts one issued RS entry per cycle and reads both source operands from the physical register file (PRF) through synchronous read ports. It patches same-cycle writeback hazards with a bypass and presents a fully resolved operand packet to the functional unit under a valid/ready handshake. It is a 2-stage pipeline: S1 is register read, S2 is the execute-input latch. It drives `busy` back to the RS when S1 cannot drain.

Parameters:
PHY_REGS, 64, number of physical registers; PHY_W = $clog2(PHY_REGS).
ROB_WIDTH, 4, ROB index width.
DATA_WIDTH, 32, operand width.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-low reset.
flush  input  1  synchronous pipeline flush.
issue_instruction  input  RS_ENTRY_t  entry from RS (addr, rob_id, funct7, funct3, rs1_phy, rs2_phy, rd_phy, immediate, opcode, predict_taken, predict_target, age, valid).
issue_valid  input  1  issue_instruction is valid this cycle.
busy  output  1  to RS; RS must not issue while high.
prf_raddr1  output  PHY_W  PRF read port 1 address.
prf_raddr2  output  PHY_W  PRF read port 2 address.
prf_rdata1  input  DATA_WIDTH  data for the address presented the previous cycle (read-before-write).
prf_rdata2  input  DATA_WIDTH  as above, port 2.
wb_valid  input  1  writeback this cycle.
wb_rd_phy  input  PHY_W  writeback destination.
wb_data  input  DATA_WIDTH  writeback value.
ex_valid  output  1  S2 holds a packet.
ex_ready  input  1  FU accepts the packet this cycle.
ex_rob_id  output  ROB_WIDTH  packet rob_id.
ex_rd_phy  output  PHY_W  packet destination.
ex_opcode  output  7  packet opcode.
ex_funct3  output  3  packet funct3.
ex_funct7  output  7  packet funct7.
ex_addr  output  32  instruction address.
ex_imm  output  32  immediate.
ex_op1  output  DATA_WIDTH  resolved rs1 value.
ex_op2  output  DATA_WIDTH  resolved rs2 value.
ex_predict_taken  output  1  passthrough.
ex_predict_target  output  32  passthrough.

Behaviour:
- Reset (rst=0, async): S1/S2 valid=0, all ex_* outputs 0, bypass flags 0, busy=0. Takes effect mid-operation with no handshake.
- Handshakes:
  - s2_free = !ex_valid || ex_ready.
  - s1_adv = s1_valid && s2_free.
  - busy = s1_valid && !s2_free (combinational).
  - Accept into S1 when issue_valid && !busy && !flush.
- Read addresses (combinational): prf_raddrN = (s1_valid && !s1_adv) ? S1.rsN_phy : issue_instruction.rsN_phy. A held S1 therefore re-reads every cycle.
- Bypass flag per source, registered every cycle into S1:
  - flagN <= wb_valid && wb_rd_phy == prf_raddrN && prf_raddrN != 0.
  - bypN <= wb_data when the flag is set.
  - Recomputed on each re-read.
- On S1→S2 transfer, opN = (rsN_phy == 0) ? 0 : flagN ? bypN : prf_rdataN.
- Latency: issue accepted in cycle t → ex_valid in cycle t+2 when there is no stall. Throughput is 1 packet/cycle.
- Simultaneous events:
  - S2 drains (ex_ready) in the same cycle S1 advances: S2 reloads, no bubble.
  - S1 advances in the same cycle a new issue is accepted: S1 reloads.
  - S2 contents are stable while ex_valid && !ex_ready.
- Flush: both stages are invalid next cycle. An issue arriving in the flush cycle is dropped. busy=0 during flush. ex_ready in the flush cycle is honoured by the FU, but the packet is dropped regardless. Flush has priority over accept/advance but not over reset.
- Only valid, ready entries arrive. No operand-readiness check is performed here.
- S1 holds at most one entry, so no overflow is possible: busy prevents a second entry.

Test Plan:
- PRF p5=0x11, p6=0x22; issue rs1=5, rs2=6, rob 3 at t, ex_ready=1 → ex_valid at t+2, op1=0x11, op2=0x22, rob_id=3; back-to-back issues every cycle → ex_valid stays high with no bubbles.
- Issue rs1=7 at t with wb p7=0x99 at t (PRF returns stale 0) → op1=0x99. Repeat with rs1=0 and wb_rd_phy=0 → op1=0.
- Hold ex_ready=0 with 2 issues → second stays in S1, busy=1, prf_raddr1 tracks S1. A wb to S1's rs2 while held → op2 takes the wb value. Raise ex_ready → packets exit in order, busy=0 that cycle.
- Pipeline full, flush asserted with issue_valid=1 → next cycle ex_valid=0, busy=0, the issued entry never appears.
- Assert rst=0 asynchronously mid-stall (between clock edges) → ex_valid and busy go 0 immediately, ex_* outputs become 0. After release, normal issue resumes with 2-cycle latency.
